// File: rtl/cpu_defs_pkg.sv
// Definitions shared by fetch, the prefetch queue and decode: word and opcode
// widths, the NOP encoding, and the opcode extraction rule.
package cpu_defs;

    localparam int WORD_W = 16;
    localparam int OPC_W  = 4;

    localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [WORD_W-1:0] word);
        return word[WORD_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/ir_prefetch_queue_ptr_counter.sv
// Modulo-DEPTH pointer with synchronous clear and increment; clear wins.
module ptr_counter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] r_ptr;

    // DEPTH is a power of two, so natural overflow of AW bits is the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + AW'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/ir_prefetch_queue.sv
// DEPTH-entry instruction prefetch queue between fetch and decode, with flush
// on taken branches and the head word/opcode presented to decode continuously.
module ir_prefetch_queue #(
    parameter int WIDTH = cpu_defs::WORD_W,
    parameter int DEPTH = 4,
    parameter int OPC_W = cpu_defs::OPC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [OPC_W-1:0]         opcode,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready never depends on out_ready (no full bypass), and
    // both handshakes are void in a flush cycle.

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    w_wr_ptr;
    logic [AW-1:0]    w_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign in_ready  = (r_count < CW'(DEPTH)) & ~flush & ~rst;
    assign out_valid = (r_count != '0);

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    ptr_counter #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (w_push),
        .ptr (w_wr_ptr)
    );

    ptr_counter #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (w_pop),
        .ptr (w_rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Empty queue shows the NOP encoding so decode never acts on stale storage.
    assign out_data = out_valid ? r_mem[w_rd_ptr] : WIDTH'(cpu_defs::NOP_WORD);
    assign opcode   = out_data[WIDTH-1 -: OPC_W];
    assign count    = r_count;

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Bench for ir_prefetch_queue: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the prefetch queue.
module tb_ir_prefetch_queue;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int OPC_W = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OPC_W-1:0] opcode;
    logic [2:0]       count;

    logic [WIDTH-1:0] exp_q[$];
    int n_checks;
    int n_fail;

    ir_prefetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OPC_W(OPC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .opcode    (opcode),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    // Model outputs are derived from the queue contents alone.
    task automatic check_model();
        logic [WIDTH-1:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : '0;
        check("count", 32'(count), 32'(exp_q.size()));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("out_data", 32'(out_data), 32'(head));
        check("opcode", 32'(opcode), 32'(head[WIDTH-1:WIDTH-OPC_W]));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH && !flush && !rst));
    endtask

    // One clock: update the model from the inputs seen at the edge, then
    // compare all outputs at the following falling edge.
    task automatic cycle();
        bit do_push;
        bit do_pop;
        @(posedge clk);
        do_push = in_valid && (exp_q.size() < DEPTH) && !flush;
        do_pop  = out_ready && (exp_q.size() != 0);
        if (flush) begin
            exp_q.delete();
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(in_data);
        end
        @(negedge clk);
        check_model();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("reset_count", 32'(count), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // 1. Reset mid-cycle with two words queued
        drive(1'b1, 16'h1111, 1'b0, 1'b0); cycle();
        drive(1'b1, 16'h2222, 1'b0, 1'b0); cycle();
        check("t1_count2", 32'(count), 32'd2);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        check("t1_rst_count", 32'(count), 32'd0);
        check("t1_rst_valid", 32'(out_valid), 32'd0);
        check("t1_rst_data", 32'(out_data), 32'h0000);
        check("t1_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t1_release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // 2. Fill and drain
        drive(1'b1, 16'h10FF, 1'b0, 1'b0); cycle();
        drive(1'b1, 16'h2A01, 1'b0, 1'b0); cycle();
        drive(1'b1, 16'h3B02, 1'b0, 1'b0); cycle();
        drive(1'b1, 16'h4C03, 1'b0, 1'b0); cycle();
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        check("t2_full_count", 32'(count), 32'd4);
        check("t2_full_in_ready", 32'(in_ready), 32'd0);
        check("t2_full_head", 32'(out_data), 32'h10FF);
        check("t2_full_opcode", 32'(opcode), 32'h1);
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle(); check("t2_drain1", 32'(out_data), 32'h2A01);
        cycle(); check("t2_drain2", 32'(out_data), 32'h3B02);
        cycle(); check("t2_drain3", 32'(out_data), 32'h4C03);
        cycle();
        check("t2_empty_valid", 32'(out_valid), 32'd0);
        check("t2_empty_data", 32'(out_data), 32'h0000);

        // 3. Simultaneous push/pop at count=2, pointers wrap
        drive(1'b1, 16'hA000, 1'b0, 1'b0); cycle();
        drive(1'b1, 16'hA001, 1'b0, 1'b0); cycle();
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 16'(16'hA001 + k), 1'b1, 1'b0);
            cycle();
            check("t3_count", 32'(count), 32'd2);
            check("t3_head", 32'(out_data), 32'(16'hA000 + k));
        end

        // 4. Full, no bypass
        drive(1'b1, 16'hB000, 1'b0, 1'b0); cycle();
        drive(1'b1, 16'hB001, 1'b0, 1'b0); cycle();
        check("t4_full", 32'(count), 32'd4);
        drive(1'b1, 16'h5D04, 1'b1, 1'b0);
        cycle();
        check("t4_pop_only_count", 32'(count), 32'd3);
        check("t4_pop_only_head", 32'(out_data), 32'hA007);
        cycle();
        check("t4_accept_count", 32'(count), 32'd3);
        check("t4_accept_head", 32'(out_data), 32'hB000);
        check("t4_tail", 32'(exp_q[exp_q.size()-1]), 32'h5D04);

        // 5. Flush at count=3 with push and pop requested
        drive(1'b1, 16'h7777, 1'b1, 1'b1);
        #1;
        check("t5_flush_in_ready", 32'(in_ready), 32'd0);
        cycle();
        check("t5_flush_count", 32'(count), 32'd0);
        check("t5_flush_valid", 32'(out_valid), 32'd0);
        drive(1'b1, 16'h6E05, 1'b0, 1'b0);
        cycle();
        check("t5_new_head", 32'(out_data), 32'h6E05);

        // 6. Opcode tracking
        drive(1'b0, '0, 1'b1, 1'b0); cycle();
        drive(1'b1, 16'hF123, 1'b0, 1'b0); cycle();
        check("t6_valid", 32'(out_valid), 32'd1);
        check("t6_opcode_f", 32'(opcode), 32'hF);
        drive(1'b0, '0, 1'b1, 1'b0); cycle();
        check("t6_opcode_0", 32'(opcode), 32'h0);

        // Random traffic, including back-to-back flushes
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b1); cycle();
        drive(1'b0, '0, 1'b0, 1'b1); cycle();
        drive(1'b0, '0, 1'b0, 1'b0); cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_prefetch_queue.md
Name: ir_prefetch_queue

Overview:
- Parametrised successor to the single-entry instruction register: a DEPTH-entry instruction prefetch queue between the fetch unit and decode.
- Fetch pushes instruction words with a valid/ready handshake; decode pops them with a second handshake.
- Flush discards all queued words when a branch or jump is taken.
- The head word and its opcode field are presented to decode continuously.

Parameters:
- WIDTH, 16, instruction word width in bits.
- DEPTH, 4, queue entries; power of two, >= 2.
- OPC_W, 4, opcode field width; the opcode is the top OPC_W bits of the word.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous flush; discards all entries.
- in_valid  input  1  fetch presents a word.
- in_ready  output  1  queue can accept a word.
- in_data  input  WIDTH  instruction word from fetch.
- out_valid  output  1  head word is valid.
- out_ready  input  1  decode consumes the head word.
- out_data  output  WIDTH  head instruction word.
- opcode  output  OPC_W  out_data[WIDTH-1 -: OPC_W].
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Clock and reset: single clock domain. rst is asynchronous and active-high. While rst is high: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_data=0, opcode=0, in_ready=0. Storage contents are don't-care.
- After reset deasserts, in_ready=1 on the next evaluation (empty queue).
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Both are sampled on the rising clk edge.
- in_ready = (count < DEPTH) & ~flush & ~rst.
  - No full-bypass: while full, in_ready=0 even if a pop is pending.
- out_valid = (count != 0).
- out_data = storage[rd_ptr] when out_valid, else all zeros, so decode sees a NOP encoding when empty.
- Latency: a word pushed on edge N appears on out_data/out_valid after edge N, i.e. one cycle from acceptance to visibility. There is no combinational in->out path.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - wr_ptr increments on push; rd_ptr increments on pop.
- count:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. Both pointers advance, which is legal whenever 0 < count < DEPTH.
- Flush:
  - On the edge where flush=1: wr_ptr=rd_ptr=0 and count=0. The flush has priority over a simultaneous push or pop.
  - The pop handshake in the flush cycle is ignored. Decode must not treat it as consumed.
  - in_ready=0 during the flush cycle, so no word is lost silently.
  - Back-to-back flush cycles hold the queue empty.
- Boundary rules:
  - Pop when empty is impossible (out_valid=0).
  - Push when full is impossible (in_ready=0).
  - The handshake rules guarantee that count never exceeds DEPTH and never underflows.
- Reset mid-operation: an asynchronous clear takes effect immediately, independent of clk. Outputs go to their reset values within the same simulation time step.
- No state machine beyond the pointer/count registers. Storage is a register array written only on push.

Decomposition:
- Shared package/header `cpu_defs`: WORD_W=16, OPC_W=4, and NOP encoding = 16'h0000. These are reused by decode and fetch.
- Optional sub-module `ptr_counter`: a modulo-DEPTH pointer with increment and clear, instantiated twice (write and read pointers).
- Storage and count logic stay in ir_prefetch_queue.

Test Plan (DEPTH=4, WIDTH=16):
1. Reset: assert rst mid-cycle with 2 words queued -> immediately count=0, out_valid=0, out_data=16'h0000. After release, in_ready=1.
2. Fill and drain:
   - Push 16'h10FF, 16'h2A01, 16'h3B02, 16'h4C03 on consecutive edges with out_ready=0 -> count=4, in_ready=0, out_data=16'h10FF, opcode=4'h1.
   - Then out_ready=1 for 4 cycles -> words emerge in order, then out_valid=0 and out_data=0.
3. Simultaneous push/pop:
   - With count=2, hold in_valid=1 and out_ready=1 for 6 cycles with incrementing data -> count stays 2, FIFO order preserved.
   - Pointers wrap past index 3 without corruption.
4. Full-no-bypass: at count=4, assert in_valid=1 with 16'h5D04 and out_ready=1 -> first edge pops only and count=3. 16'h5D04 is accepted on the next edge.
5. Flush: at count=3, assert flush with in_valid=1 and out_ready=1 for one edge -> count=0, out_valid=0, and in_ready=0 during the flush cycle. The next push of 16'h6E05 appears as the head one cycle later.
6. Opcode tracking: push 16'hF123 into an empty queue -> after one edge, out_valid=1 and opcode=4'hF. Pop it -> opcode=4'h0.
